// File: rtl/blk_e9fe45_pkg.sv
// Shared constants for the single-word storage block.
package blk_e9fe45_pkg;

  // Default stored word width in bits.
  localparam int unsigned WIDTH_DEFAULT = 16;

  // Fill bit used when clearing the word on reset (reset word is all zeros).
  localparam logic RESET_BIT = 1'b0;

  // Reset word value at the default width.
  localparam logic [0:WIDTH_DEFAULT-1] RESET_WORD = {WIDTH_DEFAULT{RESET_BIT}};

endpackage

// File: rtl/blk_e9fe45.sv
// Single-word register with valid/dirty flags and an enable-gated read mux.
// Bit 0 of data_in/data_out is the MSB.
module blk_e9fe45
  import blk_e9fe45_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             enable,
  input  logic             write,
  input  logic [0:WIDTH-1] data_in,
  output logic [0:WIDTH-1] data_out,
  input  logic             clk,
  input  logic             reset,
  output logic             valid,
  output logic             dirty
);

  logic [0:WIDTH-1] r_word;
  logic             r_valid;
  logic             r_dirty;
  logic             w_wr;

  // A write only qualifies when the block is selected; enable=0 masks an X/Z strobe.
  assign w_wr = enable && write;

  // Word and flags: async clear dominates, otherwise load on a qualified write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word  <= {WIDTH{RESET_BIT}};
      r_valid <= 1'b0;
      r_dirty <= 1'b0;
    end else if (w_wr) begin
      r_word  <= data_in;
      r_valid <= 1'b1;
      r_dirty <= 1'b1;
    end
  end

  // Read mux: stored word while selected, zeros otherwise.
  always_comb begin
    data_out = '0;
    if (enable) begin
      data_out = r_word;
    end
  end

  assign valid = r_valid;
  assign dirty = r_dirty;

endmodule

// File: tb/tb_blk_e9fe45.sv
// Directed bench for blk_e9fe45 with a behavioural reference model and per-cycle compare.
module tb_blk_e9fe45;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         write;
  logic [0:W-1] data_in;
  logic [0:W-1] data_out;
  logic         valid;
  logic         dirty;

  int unsigned n_vec;
  int unsigned n_bad;
  bit          run;

  // Reference model state: what the word and flags must hold by the rules.
  logic [0:W-1] m_word;
  logic         m_written;

  blk_e9fe45 #(.WIDTH(W)) dut (
    .enable   (enable),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out),
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .dirty    (dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: reset wipes everything at once; a selected write stores data_in.
  always @(posedge reset) begin
    m_word    = '0;
    m_written = 1'b0;
  end

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_word    = '0;
      m_written = 1'b0;
    end else if (enable === 1'b1 && write === 1'b1) begin
      m_word    = data_in;
      m_written = 1'b1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      chk("cyc_data_out", {16'h0, data_out}, {16'h0, (enable === 1'b1) ? m_word : 16'h0000});
      chk("cyc_valid",    {31'h0, valid},    {31'h0, m_written});
      chk("cyc_dirty",    {31'h0, dirty},    {31'h0, m_written});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    run       = 1'b0;
    m_word    = '0;
    m_written = 1'b0;
    reset     = 1'b1;
    enable    = 1'b0;
    write     = 1'b0;
    data_in   = '0;
    #12;
    reset = 1'b0;
    run   = 1'b1;
    step();

    // Reset then idle.
    chk("idle_data_out", {16'h0, data_out}, 32'h0000);
    chk("idle_valid", {31'h0, valid}, 32'h0);
    chk("idle_dirty", {31'h0, dirty}, 32'h0);

    // Unwritten read while selected.
    enable = 1'b1;
    #1;
    chk("unwritten_read", {16'h0, data_out}, 32'h0000);
    chk("unwritten_valid", {31'h0, valid}, 32'h0);

    // Write 0x0F0F: old word visible before the edge, new word right after.
    write   = 1'b1;
    data_in = 16'h0F0F;
    #1;
    chk("no_passthrough", {16'h0, data_out}, 32'h0000);
    step();
    write = 1'b0;
    chk("write_data", {16'h0, data_out}, 32'h0F0F);
    chk("write_valid", {31'h0, valid}, 32'h1);
    chk("write_dirty", {31'h0, dirty}, 32'h1);

    // Disabled write is ignored.
    enable  = 1'b0;
    write   = 1'b1;
    data_in = 16'hFFFF;
    step();
    chk("disabled_out_zero", {16'h0, data_out}, 32'h0000);
    chk("disabled_valid_seen", {31'h0, valid}, 32'h1);
    write  = 1'bx;
    step();
    write  = 1'b0;
    enable = 1'b1;
    #1;
    chk("disabled_word_kept", {16'h0, data_out}, 32'h0F0F);

    // Back-to-back writes, last wins.
    write   = 1'b1;
    data_in = 16'h1234;
    step();
    chk("b2b_first", {16'h0, data_out}, 32'h1234);
    data_in = 16'hABCD;
    step();
    write = 1'b0;
    chk("b2b_last", {16'h0, data_out}, 32'hABCD);

    // Asynchronous reset mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_data", {16'h0, data_out}, 32'h0000);
    chk("async_rst_valid", {31'h0, valid}, 32'h0);
    chk("async_rst_dirty", {31'h0, dirty}, 32'h0);

    // Reset/write collision: write blocked while reset is high.
    write   = 1'b1;
    data_in = 16'h5555;
    step();
    chk("collision_word", {16'h0, data_out}, 32'h0000);
    chk("collision_valid", {31'h0, valid}, 32'h0);
    enable = 1'b0;
    #1;
    chk("reset_out_disabled", {16'h0, data_out}, 32'h0000);

    // First qualifying edge after reset release writes normally.
    enable = 1'b1;
    reset  = 1'b0;
    step();
    write = 1'b0;
    chk("post_reset_write", {16'h0, data_out}, 32'h5555);
    chk("post_reset_valid", {31'h0, valid}, 32'h1);
    step();
    step();

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/blk_e9fe45.md
BLOCK -- requirements
Module: block

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the stored word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: block select, gating both read and write.
REQ-005 The block SHALL have port write, input, 1 bit: write strobe, qualified by enable.
REQ-006 The block SHALL have port data_in, input, [0:WIDTH-1]: write data, bit 0 is the MSB.
REQ-007 The block SHALL have port data_out, output, [0:WIDTH-1]: read data, bit 0 is the MSB.
REQ-008 The block SHALL have port valid, output, 1 bit: the word has been written since reset.
REQ-009 The block SHALL have port dirty, output, 1 bit: the word has been modified since reset.
REQ-010 The block SHALL use positional port order enable, write, data_in, data_out, clk, reset, valid, dirty, so existing four-port positional instantiations remain legal.

Function
REQ-011 Storage SHALL be one WIDTH-bit word register plus one valid flag and one dirty flag.
REQ-012 When enable=1 and write=1 at a rising clk edge, the block SHALL load data_in into the word and set valid=1 and dirty=1.
REQ-013 With enable=0, write SHALL be ignored, and word, valid and dirty SHALL hold.
REQ-014 With enable=1 and write=0, the state SHALL hold.
REQ-015 data_out SHALL be combinational: the stored word when enable=1, all zeros when enable=0.
REQ-016 The write latency SHALL be one edge, so data_out reflects newly written data immediately after the capturing edge while enable=1.
REQ-017 data_out SHALL not pass data_in through combinationally during a write; before the edge it shows the old word.
REQ-018 Reading an unwritten word with enable=1 SHALL return all zeros, with valid=0.
REQ-019 Back-to-back writes on consecutive edges SHALL each take effect, with the last write winning.
REQ-020 valid and dirty SHALL be registered and observable regardless of enable.
REQ-021 X or Z on write while enable=0 SHALL NOT corrupt the stored state.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for clk, clear the word to 0, valid to 0 and dirty to 0.
REQ-023 While reset=1, writes SHALL be blocked.
REQ-024 After reset is deasserted, the first qualifying rising edge SHALL write normally.
REQ-025 Reset asserted in the same cycle as a write SHALL take priority, leaving the word at 0.
REQ-026 data_out during reset SHALL be 0, whatever the value of enable.

Structure
REQ-027 A shared package SHALL hold the default WIDTH constant (16) and the reset word value (all zeros).
REQ-028 The block SHALL be a single module with no sub-modules; the word register, flags and output mux are implemented inline.

Verification
REQ-029 Reset then idle: reset=1 then 0, enable=0 -> data_out=0x0000, valid=0, dirty=0.
REQ-030 Write: enable=1, write=1, data_in=0x0F0F, one rising edge, then write=0 -> data_out=0x0F0F, valid=1, dirty=1.
REQ-031 Disabled write: enable=0, write=1, data_in=0xFFFF over an edge -> word unchanged; data_out=0 while enable=0 and 0x0F0F once enable=1.
REQ-032 Overwrite: write 0x1234 then 0xABCD on consecutive edges -> data_out=0xABCD.
REQ-033 Asynchronous reset: assert reset mid-cycle after storing 0xABCD -> data_out=0, valid=0 and dirty=0 immediately, before the next clk edge.
REQ-034 Reset/write collision: reset=1 with enable=1, write=1, data_in=0x5555 at an edge -> word stays 0.
